// File: rtl/led_pkg.sv
// Mode encodings and per-mode LED start patterns shared by the LED sequencer.
// Constants only; no latency, no flow control.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_COUNT = 2'd0,
      MODE_SCAN  = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_FILL  = 2'd3
   } mode_t;

   localparam logic [7:0] START_COUNT = 8'h00;
   localparam logic [7:0] START_SCAN  = 8'h01;
   localparam logic [7:0] START_BLINK = 8'h00;
   localparam logic [7:0] START_FILL  = 8'h00;

   function automatic logic [7:0] start_value(input mode_t m);
      logic [7:0] v;
      unique case (m)
         MODE_COUNT: v = START_COUNT;
         MODE_SCAN:  v = START_SCAN;
         MODE_BLINK: v = START_BLINK;
         MODE_FILL:  v = START_FILL;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/led_debounce.sv
// Two-flop synchroniser plus level debouncer for an asynchronous pushbutton.
// dout follows din 2+DEB_CYCLES cycles after din settles; no backpressure.
module led_debounce #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic CLK,
   input  logic RESETN,
   input  logic din,
   output logic dout
);

   localparam int CW = $clog2(DEB_CYCLES);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   // cnt measures how long s2 has disagreed with dout; any agreement restarts it
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         cnt  <= '0;
         dout <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         if (s2 == dout) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            dout <= s2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/led_sequencer.sv
// Prescaled LED pattern generator with four modes cycled by a debounced button.
// LD/MODE registered, one cycle after tick or debounced press; no backpressure.
module led_sequencer
   import led_pkg::*;
#(
   parameter int BASE_BIT   = 24,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       BTNC,
   input  logic [1:0] SPEED,
   input  logic       PAUSE,
   output logic [7:0] LD,
   output logic [1:0] MODE
);

   logic [1:0]  rst_sync;
   logic        arst_n;
   logic        deb;
   logic        deb_q;
   logic        rise;
   logic [31:0] presc;
   logic [4:0]  tick_bit;
   logic [31:0] tick_mask;
   logic        tick;
   logic        scan_right;
   mode_t       mode;
   mode_t       next_mode;

   // assert asynchronously, release two edges after RESETN rises
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end
   assign arst_n = rst_sync[1];

   led_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
      .CLK    (CLK),
      .RESETN (arst_n),
      .din    (BTNC),
      .dout   (deb)
   );

   assign rise      = deb & ~deb_q;
   assign next_mode = mode_t'(mode + 2'd1);
   assign tick_bit  = 5'(BASE_BIT) - {3'b000, SPEED};
   assign tick_mask = 32'hFFFF_FFFF >> (5'd31 - tick_bit);
   assign tick      = (presc & tick_mask) == tick_mask;
   assign MODE      = mode;

   // a mode advance restarts the prescaler and swallows a coincident tick
   always_ff @(posedge CLK or negedge arst_n) begin
      if (!arst_n) begin
         presc      <= '0;
         mode       <= MODE_COUNT;
         LD         <= START_COUNT;
         scan_right <= 1'b0;
         deb_q      <= 1'b0;
      end else begin
         deb_q <= deb;
         if (rise) begin
            mode       <= next_mode;
            LD         <= start_value(next_mode);
            scan_right <= 1'b0;
            presc      <= '0;
         end else begin
            presc <= presc + 32'd1;
            if (tick && !PAUSE) begin
               unique case (mode)
                  MODE_COUNT: LD <= LD + 8'd1;
                  MODE_SCAN: begin
                     if (!scan_right) begin
                        if (LD == 8'h80) begin
                           scan_right <= 1'b1;
                           LD         <= 8'h40;
                        end else begin
                           LD <= LD << 1;
                        end
                     end else begin
                        if (LD == 8'h01) begin
                           scan_right <= 1'b0;
                           LD         <= 8'h02;
                        end else begin
                           LD <= LD >> 1;
                        end
                     end
                  end
                  MODE_BLINK: LD <= ~LD;
                  MODE_FILL:  LD <= (LD == 8'hFF) ? 8'h00 : {LD[6:0], 1'b1};
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed-plus-random bench for led_sequencer against a tick-count reference model.
module tb_led_sequencer;

   localparam int BASE = 3;
   localparam int DEB  = 4;

   logic       CLK;
   logic       RESETN;
   logic       BTNC;
   logic [1:0] SPEED;
   logic       PAUSE;
   logic [7:0] LD;
   logic [1:0] MODE;

   int checks   = 0;
   int failures = 0;

   // model: mode, ticks applied since mode entry, cycles since phase start
   int       m_mode;
   int       m_n;
   longint   m_c;
   int       hold;
   bit       deb1;
   bit       deb2;
   bit [7:0] hist;

   led_sequencer #(.BASE_BIT(BASE), .DEB_CYCLES(DEB)) dut (
      .CLK    (CLK),
      .RESETN (RESETN),
      .BTNC   (BTNC),
      .SPEED  (SPEED),
      .PAUSE  (PAUSE),
      .LD     (LD),
      .MODE   (MODE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [7:0] pat(input int mode, input int n);
      int p;
      case (mode)
         0: return 8'(n % 256);
         1: begin
            p = n % 14;
            return 8'(1 << ((p <= 7) ? p : 14 - p));
         end
         2: return (n % 2 == 1) ? 8'hFF : 8'h00;
         default: return 8'((1 << (n % 9)) - 1);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_n    = 0;
      m_c    = 0;
      hold   = 2;
      deb1   = 1'b0;
      deb2   = 1'b0;
      hist   = '0;
   endtask

   task automatic step();
      bit adv, dn, all1, all0, tk;
      longint per;
      if (!RESETN) begin
         model_reset();
      end else if (hold > 0) begin
         hold--;
      end else begin
         hist = {hist[6:0], BTNC};
         adv  = deb1 && !deb2;
         all1 = 1'b1;
         all0 = 1'b1;
         for (int i = 2; i <= DEB + 1; i++) begin
            if (hist[i]) all0 = 1'b0;
            else         all1 = 1'b0;
         end
         dn = all1 ? 1'b1 : (all0 ? 1'b0 : deb1);
         deb2 = deb1;
         deb1 = dn;
         if (adv) begin
            m_mode = (m_mode + 1) % 4;
            m_n    = 0;
            m_c    = 0;
         end else begin
            per = longint'(1) << (BASE - int'(SPEED) + 1);
            tk  = (m_c % per) == per - 1;
            m_c++;
            if (tk && !PAUSE) m_n++;
         end
      end
      @(posedge CLK);
      #1;
      chk("ld_model", LD, pat(m_mode, m_n));
      chk("mode_model", {6'b0, MODE}, 8'(m_mode));
   endtask

   task automatic press(input int len);
      BTNC = 1'b1;
      repeat (len) step();
      BTNC = 1'b0;
      repeat (12) step();
   endtask

   // press timed so the advance edge coincides with a tick (SPEED=3 ticks on odd counts)
   task automatic collide(input string tag, input logic [7:0] exp_ld, input logic [1:0] exp_mode);
      SPEED = 2'd3;
      if (m_c % 2 == 0) step();
      BTNC = 1'b1;
      repeat (7) step();
      chk({tag, "_ld"}, LD, exp_ld);
      chk({tag, "_mode"}, {6'b0, MODE}, {6'b0, exp_mode});
      repeat (3) step();
      BTNC = 1'b0;
      repeat (12) step();
   endtask

   initial begin
      RESETN = 1'b0;
      BTNC   = 1'b0;
      SPEED  = 2'd0;
      PAUSE  = 1'b0;
      model_reset();
      repeat (3) step();
      chk("reset_ld", LD, 8'h00);
      chk("reset_mode", {6'b0, MODE}, 8'h00);

      // COUNT at slowest speed: 2 release edges, then a tick every 16 cycles
      RESETN = 1'b1;
      repeat (18) step();
      chk("count_first", LD, 8'h01);
      repeat (16) step();
      chk("count_second", LD, 8'h02);
      repeat (16) step();
      chk("count_third", LD, 8'h03);
      repeat (253 * 16) step();
      chk("count_wrap", LD, 8'h00);

      SPEED = 2'd3;
      repeat (20) step();
      SPEED = 2'd0;
      repeat (20) step();

      // short press is rejected, long press advances exactly once
      BTNC = 1'b1;
      repeat (3) step();
      BTNC = 1'b0;
      repeat (12) step();
      chk("short_press_mode", {6'b0, MODE}, 8'h00);
      BTNC = 1'b1;
      repeat (7) step();
      chk("press_mode", {6'b0, MODE}, 8'h01);
      chk("press_ld", LD, 8'h01);
      repeat (3) step();
      BTNC = 1'b0;
      repeat (12) step();
      chk("held_once_mode", {6'b0, MODE}, 8'h01);

      SPEED = 2'd3;
      repeat (40) step();

      press($urandom_range(5, 12));
      repeat ($urandom_range(10, 30)) step();
      press($urandom_range(5, 12));
      chk("fill_mode", {6'b0, MODE}, 8'h03);
      SPEED = 2'd2;
      repeat (30) step();
      PAUSE = 1'b1;
      repeat (100) step();
      PAUSE = 1'b0;
      repeat (40) step();

      collide("collide_fill_count", 8'h00, 2'd0);
      collide("collide_count_scan", 8'h01, 2'd1);
      press($urandom_range(5, 12));
      SPEED = 2'd3;
      for (int i = 0; i < 8 && pat(m_mode, m_n) != 8'hFF; i++) step();
      chk("blink_on", LD, 8'hFF);
      RESETN = 1'b0;
      #1;
      chk("async_reset_ld", LD, 8'h00);
      chk("async_reset_mode", {6'b0, MODE}, 8'h00);
      model_reset();
      repeat (3) step();
      RESETN = 1'b1;
      repeat (20) step();

      for (int k = 0; k < 40; k++) begin
         BTNC  = 1'($urandom_range(0, 1));
         SPEED = 2'($urandom_range(0, 3));
         PAUSE = ($urandom_range(0, 3) == 0);
         repeat ($urandom_range(1, 15)) step();
      end

      // reset in the middle of debouncing must not yield an advance
      BTNC  = 1'b0;
      PAUSE = 1'b0;
      repeat (12) step();
      RESETN = 1'b0;
      #1;
      model_reset();
      repeat (2) step();
      RESETN = 1'b1;
      repeat (20) step();
      BTNC = 1'b1;
      repeat (4) step();
      RESETN = 1'b0;
      BTNC   = 1'b0;
      #1;
      chk("mid_deb_reset_mode", {6'b0, MODE}, 8'h00);
      model_reset();
      repeat (3) step();
      RESETN = 1'b1;
      repeat (30) step();
      chk("no_adv_after_reset", {6'b0, MODE}, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
